// File: rtl/maj_net_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : maj_net_sequencer
//  Description : Programmable network of up to eight 3-input majority nodes.
//                One shared majority unit evaluates one node per cycle over
//                a captured 7-bit input vector. The last node's value is
//                presented through a valid/ready result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module maj_net_sequencer #(
  parameter int N_NODES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // configuration port
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [14:0] cfg_data,
  output logic        cfg_err,
  // input vector handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  x,
  // result handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_eval = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  // Code 7 on all three operands with no inversion: the node evaluates to 0.
  localparam logic [14:0] c_entry_rst = {1'b0, 4'd7, 1'b0, 4'd7, 1'b0, 4'd7};

  // Highest valid configuration address (length register).
  localparam logic [3:0] c_addr_len = 4'd8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [2:0]  r_ptr;
  logic [2:0]  r_len;
  logic [6:0]  r_x;
  logic [N_NODES-1:0] r_node;
  logic        r_out;
  logic        r_cfg_err;
  logic [14:0] r_cfg [N_NODES];

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic        w_idle;
  logic        w_accept;
  logic        w_cfg_ok;
  logic        w_cfg_bad;
  logic [14:0] w_entry;
  logic [7:0]  w_xext;
  logic        w_a;
  logic        w_b;
  logic        w_c;
  logic        w_maj;
  logic        w_last;

  // Operand select: codes 0-6 pick an input bit, 7 picks the zero that pads
  // the extended input vector, 8-15 pick a node result. Inversion is an XOR.
  function automatic logic f_operand(input logic [3:0] sel,
                                     input logic       inv,
                                     input logic [7:0] xv,
                                     input logic [7:0] wv);
    logic v;
    if (sel[3]) begin
      v = wv[sel[2:0]];
    end else begin
      v = xv[sel[2:0]];
    end
    return v ^ inv;
  endfunction

  assign w_idle    = (r_state == c_st_idle);
  assign w_accept  = w_idle && in_valid;
  // Writes are only legal while idle and only to the node table or length.
  assign w_cfg_ok  = cfg_we && w_idle && (cfg_addr <= c_addr_len);
  assign w_cfg_bad = cfg_we && !w_cfg_ok;

  assign w_entry = r_cfg[r_ptr];
  assign w_xext  = {1'b0, r_x};
  assign w_last  = (r_ptr == r_len);

  // Decode the current node entry and feed the single shared majority unit.
  always_comb begin
    w_a   = f_operand(w_entry[3:0],   w_entry[4],  w_xext, r_node);
    w_b   = f_operand(w_entry[8:5],   w_entry[9],  w_xext, r_node);
    w_c   = f_operand(w_entry[13:10], w_entry[14], w_xext, r_node);
    w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
  end

  // --------------------------------------------------------------------------
  // Configuration storage
  // --------------------------------------------------------------------------
  // Node table and length register; rejected writes raise a one-cycle error.
  // A write coinciding with an accept lands at the same edge, so the
  // evaluation that follows already sees the new program.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_cfg[i] <= c_entry_rst;
      end
      r_len     <= 3'd0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
      if (w_cfg_ok) begin
        if (cfg_addr[3]) begin
          r_len <= cfg_data[2:0];
        end else begin
          r_cfg[cfg_addr[2:0]] <= cfg_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM and node result register
  // --------------------------------------------------------------------------
  // IDLE captures a vector and clears all node results (so forward and self
  // references read 0), EVAL computes one node per cycle, HOLD presents out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_ptr   <= 3'd0;
      r_x     <= 7'd0;
      r_node  <= '0;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_x     <= x;
            r_node  <= '0;
            r_ptr   <= 3'd0;
            r_state <= c_st_eval;
          end
        end
        c_st_eval: begin
          r_node[r_ptr] <= w_maj;
          if (w_last) begin
            r_out   <= w_maj;
            r_state <= c_st_hold;
          end else begin
            r_ptr <= r_ptr + 3'd1;
          end
        end
        c_st_hold: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = w_idle;
  assign out_valid = (r_state == c_st_hold);
  assign busy      = !w_idle;
  assign out       = r_out;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
